// File: rtl/mem_arbiter.sv
// mem_arbiter: registered one-transaction-at-a-time arbiter sharing the memory port
// between fetch (read-only) and exec (read/write), with alignment handling and a bus watchdog.
module mem_arbiter #(
    parameter int ARB_MODE       = 0,
    parameter int ALIGN_CHECK    = 0,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] f_address,
    input  logic [1:0]  f_datasize,
    input  logic        f_read,
    output logic [63:0] f_readdata,
    output logic        f_done,
    output logic        f_fault,
    input  logic [63:0] x_address,
    input  logic [1:0]  x_datasize,
    input  logic        x_read,
    input  logic        x_write,
    input  logic [63:0] x_writedata,
    output logic [63:0] x_readdata,
    output logic        x_done,
    output logic        x_fault,
    output logic [63:0] mem_address,
    output logic [1:0]  mem_datasize,
    output logic        mem_read,
    output logic        mem_write,
    output logic [63:0] mem_writedata,
    input  logic [63:0] mem_readdata,
    input  logic        mem_done,
    output logic        timeout_err
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    localparam logic [31:0] WD_LAST = 32'(TIMEOUT_CYCLES - 1);
    state_t      state, state_nxt;
    logic [63:0] cmd_address, cmd_writedata, rdata, sel_address;
    logic [1:0]  cmd_datasize, sel_datasize;
    logic [31:0] wdog;
    logic [2:0]  mask;
    logic        cmd_write, owner, fault, rr_exec;
    logic        f_req, x_req, req, grant_x, misalign, rw_fault, timeout, busy, done;
    assign f_req        = f_read;
    assign x_req        = x_read | x_write;
    assign req          = f_req | x_req;
    // rr_exec names the winner of the next tie; exec always wins ties in priority mode
    assign grant_x      = x_req & (~f_req | (ARB_MODE == 0) | rr_exec);
    assign sel_address  = grant_x ? x_address : f_address;
    assign sel_datasize = grant_x ? x_datasize : f_datasize;
    assign mask         = 3'((4'd1 << sel_datasize) - 4'd1);
    assign misalign     = (ALIGN_CHECK != 0) && |(sel_address[2:0] & mask);
    assign rw_fault     = grant_x & x_read & x_write;
    assign timeout      = (TIMEOUT_CYCLES != 0) && wdog == WD_LAST;
    assign busy         = state == BUSY;
    assign done         = state == DONE;
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    state_nxt = !req ? IDLE : (misalign || rw_fault) ? DONE : BUSY;
            BUSY:    state_nxt = (mem_done || timeout) ? DONE : BUSY;
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            cmd_address   <= '0;
            cmd_datasize  <= '0;
            cmd_writedata <= '0;
            cmd_write     <= 1'b0;
            owner         <= 1'b0;
            fault         <= 1'b0;
            rdata         <= '0;
            rr_exec       <= 1'b0;
            wdog          <= '0;
            timeout_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            unique case (state)
                IDLE: if (req) begin
                    owner         <= grant_x;
                    cmd_address   <= ALIGN_CHECK != 0 ? sel_address : sel_address & ~{61'd0, mask};
                    cmd_datasize  <= sel_datasize;
                    cmd_write     <= grant_x & x_write;
                    cmd_writedata <= grant_x ? x_writedata : '0;
                    fault         <= misalign | rw_fault;
                    rdata         <= '0;
                    if (ARB_MODE != 0 && f_req && x_req) rr_exec <= ~grant_x;
                end
                BUSY: if (mem_done) begin
                    rdata <= cmd_write ? '0 : mem_readdata;
                    fault <= 1'b0;
                end else if (timeout) begin
                    rdata       <= '0;
                    fault       <= 1'b1;
                    timeout_err <= 1'b1;
                end else begin
                    wdog <= wdog + 32'd1;
                end
                default: wdog <= '0;
            endcase
        end
    end
    // memory side is quiet outside BUSY so stale command regs never reach the bus
    assign mem_address   = busy ? cmd_address : '0;
    assign mem_datasize  = busy ? cmd_datasize : '0;
    assign mem_writedata = busy ? cmd_writedata : '0;
    assign mem_read      = busy & ~cmd_write;
    assign mem_write     = busy & cmd_write;
    assign f_done        = done & ~owner;
    assign x_done        = done & owner;
    assign f_fault       = f_done & fault;
    assign x_fault       = x_done & fault;
    assign f_readdata    = f_done ? rdata : '0;
    assign x_readdata    = x_done ? rdata : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized bench against a transaction-level model; instance 0 is
// priority/force-align, instance 1 is round-robin/align-check, both with an 8-cycle watchdog.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;
    logic [63:0] f_address [2], f_readdata [2], x_address [2], x_writedata [2], x_readdata [2];
    logic [63:0] mem_address [2], mem_writedata [2], mem_readdata [2];
    logic [1:0]  f_datasize [2], x_datasize [2], mem_datasize [2];
    logic        f_read [2], f_done [2], f_fault [2], x_read [2], x_write [2], x_done [2], x_fault [2];
    logic        mem_read [2], mem_write [2], mem_done [2], timeout_err [2];
    int          checks = 0, errors = 0;
    bit          tie_x [2];
    bit          te [2];
    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_arbiter #(.ARB_MODE(g), .ALIGN_CHECK(g), .TIMEOUT_CYCLES(8)) u_dut (
            .clk(clk), .reset(reset),
            .f_address(f_address[g]), .f_datasize(f_datasize[g]), .f_read(f_read[g]),
            .f_readdata(f_readdata[g]), .f_done(f_done[g]), .f_fault(f_fault[g]),
            .x_address(x_address[g]), .x_datasize(x_datasize[g]), .x_read(x_read[g]),
            .x_write(x_write[g]), .x_writedata(x_writedata[g]), .x_readdata(x_readdata[g]),
            .x_done(x_done[g]), .x_fault(x_fault[g]),
            .mem_address(mem_address[g]), .mem_datasize(mem_datasize[g]), .mem_read(mem_read[g]),
            .mem_write(mem_write[g]), .mem_writedata(mem_writedata[g]), .mem_readdata(mem_readdata[g]),
            .mem_done(mem_done[g]), .timeout_err(timeout_err[g])
        );
    end
    function automatic logic [264:0] outs(input int d);
        return {f_readdata[d], f_done[d], f_fault[d], x_readdata[d], x_done[d], x_fault[d],
                mem_address[d], mem_datasize[d], mem_read[d], mem_write[d], mem_writedata[d], timeout_err[d]};
    endfunction
    task automatic clear(input int d);
        f_read[d] = 0; f_address[d] = '0; f_datasize[d] = '0;
        x_read[d] = 0; x_write[d] = 0; x_address[d] = '0; x_datasize[d] = '0; x_writedata[d] = '0;
        mem_done[d] = 0; mem_readdata[d] = '0;
    endtask
    // Expected outcome of one granted request, straight from the alignment/fault/latency rules
    function automatic void plan(input int d, input int o, input bit xr, input bit xw,
                                 input logic [63:0] fa, input logic [63:0] xa, input logic [1:0] fds,
                                 input logic [1:0] xds, input int lf, input int lx,
                                 output int l, output bit flt, output bit tmo, output bit ew,
                                 output logic [63:0] ea, output logic [1:0] eds);
        logic [63:0] a = o == 1 ? xa : fa;
        logic [1:0]  ds = o == 1 ? xds : fds;
        logic [63:0] m = (64'd1 << ds) - 64'd1;
        int          lat = o == 1 ? lx : lf;
        bit          sf = (o == 1 && xr && xw) || (d == 1 && (a & m) != 0);
        l   = sf ? 0 : (lat == 0 ? 8 : lat);
        tmo = !sf && lat == 0;
        flt = sf || tmo;
        ew  = o == 1 && xw;
        ea  = a & ~m;
        eds = ds;
    endfunction
    task automatic run(input string nm, input int d, input bit fr, input bit xr, input bit xw,
                       input logic [63:0] fa, input logic [1:0] fds, input logic [63:0] xa,
                       input logic [1:0] xds, input logic [63:0] wd, input int lf, input int lx);
        int o, o2, cnt, k, l, ed;
        bit flt, tmo, ew, in_busy, gf;
        logic [63:0] ea, er, gr;
        logic [1:0] eds;
        if (fr && (xr || xw)) begin
            o = (d == 0 || tie_x[d]) ? 1 : 0;
            if (d == 1) tie_x[d] = o == 0;
            o2 = 1 - o;
            cnt = 2;
        end else begin
            o = (xr || xw) ? 1 : 0;
            o2 = 0;
            cnt = 1;
        end
        f_read[d] = fr; f_address[d] = fa; f_datasize[d] = fds;
        x_read[d] = xr; x_write[d] = xw; x_address[d] = xa; x_datasize[d] = xds; x_writedata[d] = wd;
        mem_done[d] = 0;
        plan(d, o, xr, xw, fa, xa, fds, xds, lf, lx, l, flt, tmo, ew, ea, eds);
        ed = 1 + l;
        er = '0;
        k = 0;
        for (int n = 1; n <= 40 && k < cnt; n++) begin
            @(negedge clk);
            in_busy = n >= ed - l && n < ed;
            checks++;
            if (mem_read[d] !== (in_busy && !ew) || mem_write[d] !== (in_busy && ew)) begin
                errors++;
                $display("FAIL %s d%0d cyc%0d mem_rw: got r=%b w=%b, want r=%b w=%b", nm, d, n,
                         mem_read[d], mem_write[d], in_busy && !ew, in_busy && ew);
            end
            if (in_busy) begin
                checks++;
                if (mem_address[d] !== ea || mem_datasize[d] !== eds || (ew && mem_writedata[d] !== wd)) begin
                    errors++;
                    $display("FAIL %s d%0d cyc%0d mem_cmd: got a=%h ds=%0d wd=%h, want a=%h ds=%0d wd=%h", nm, d, n,
                             mem_address[d], mem_datasize[d], mem_writedata[d], ea, eds, wd);
                end
            end
            checks++;
            if (f_done[d] !== (n == ed && o == 0) || x_done[d] !== (n == ed && o == 1)) begin
                errors++;
                $display("FAIL %s d%0d cyc%0d done: got f=%b x=%b, want f=%b x=%b", nm, d, n,
                         f_done[d], x_done[d], n == ed && o == 0, n == ed && o == 1);
            end
            if (n == ed) begin
                gf = o == 1 ? x_fault[d] : f_fault[d];
                gr = o == 1 ? x_readdata[d] : f_readdata[d];
                checks++;
                if (gf !== flt || gr !== er) begin
                    errors++;
                    $display("FAIL %s d%0d cyc%0d result: got fault=%b data=%h, want fault=%b data=%h", nm, d, n,
                             gf, gr, flt, er);
                end
                if (tmo) te[d] = 1;
                if (o == 1) begin x_read[d] = 0; x_write[d] = 0; end else f_read[d] = 0;
                k++;
                if (k < cnt) begin
                    o = o2;
                    plan(d, o, xr, xw, fa, xa, fds, xds, lf, lx, l, flt, tmo, ew, ea, eds);
                    ed = n + 2 + l;
                    er = '0;
                end
            end
            mem_readdata[d] = {$urandom, $urandom};
            if (in_busy && n == ed - 1 && !tmo) begin
                mem_done[d] = 1;
                er = ew ? '0 : mem_readdata[d];
            end else begin
                mem_done[d] = in_busy ? 1'b0 : 1'($urandom_range(0, 1));
            end
        end
        if (k < cnt) begin
            errors++;
            $display("FAIL %s d%0d completion: got %0d of %0d done pulses within 40 cycles", nm, d, k, cnt);
        end
        clear(d);
        @(negedge clk);
        checks++;
        if (timeout_err[d] !== te[d]) begin
            errors++;
            $display("FAIL %s d%0d timeout_err: got %b, want %b", nm, d, timeout_err[d], te[d]);
        end
    endtask
    task automatic test_reset;
        clear(0); clear(1);
        reset = 1;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (outs(d) !== '0) begin
                errors++;
                $display("FAIL reset d%0d outputs: got %h, want 0", d, outs(d));
            end
            tie_x[d] = 0;
            te[d] = 0;
        end
        reset = 0;
        @(negedge clk);
    endtask
    task automatic test_fetch_read;
        for (int d = 0; d < 2; d++) run("fetch_read", d, 1, 0, 0, 64'hffff_ffff_ffff_fffc, 2'd2, '0, '0, '0, 2, 1);
    endtask
    task automatic test_arbitration;
        logic [63:0] fa, xa;
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 4; i++) begin
                fa = {$urandom, $urandom & 32'hffff_fff8};
                xa = {$urandom, $urandom & 32'hffff_fff8};
                run("tie", d, 1, i[0], !i[0], fa, 2'($urandom), xa, 2'($urandom), {$urandom, $urandom},
                    $urandom_range(1, 4), $urandom_range(1, 4));
            end
    endtask
    task automatic test_align;
        for (int d = 0; d < 2; d++) begin
            run("align_wr", d, 0, 0, 1, '0, '0, 64'h1007, 2'd3, 64'hdead_beef_0123_4567, 1, 2);
            run("align_rd", d, 1, 0, 0, 64'h2003, 2'd1, '0, '0, '0, 1, 1);
        end
    endtask
    task automatic test_rw_fault;
        for (int d = 0; d < 2; d++) run("rw_fault", d, 0, 1, 1, '0, '0, 64'h40, 2'd3, 64'h55, 1, 1);
    endtask
    task automatic test_timeout;
        for (int d = 0; d < 2; d++) begin
            run("timeout", d, 0, 1, 0, '0, '0, 64'h80, 2'd3, '0, 1, 0);
            run("after_timeout", d, 1, 0, 0, 64'h100, 2'd3, '0, '0, '0, 3, 1);
        end
    endtask
    task automatic test_back_to_back;
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 4; i++)
                run("back_to_back", d, 1, 0, 0, {$urandom, $urandom & 32'hffff_fff8}, 2'($urandom), '0, '0, '0, 1, 1);
    endtask
    task automatic test_random;
        bit fr, xr, xw;
        logic [63:0] fa, xa;
        for (int i = 0; i < 80; i++) begin
            fr = 1'($urandom); xr = 1'($urandom); xw = 1'($urandom);
            if (!fr && !xr && !xw) fr = 1;
            fa = {$urandom, $urandom}; xa = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 1) fa[2:0] = 3'd0;
            if ($urandom_range(0, 1) == 1) xa[2:0] = 3'd0;
            run("random", i % 2, fr, xr, xw, fa, 2'($urandom), xa, 2'($urandom), {$urandom, $urandom},
                $urandom_range(0, 9) == 0 ? 0 : $urandom_range(1, 5), $urandom_range(0, 9) == 0 ? 0 : $urandom_range(1, 5));
        end
    endtask
    task automatic test_reset_mid(input int d);
        f_read[d] = 1; f_address[d] = 64'h3000; f_datasize[d] = 2'd3; mem_done[d] = 0;
        repeat (3) @(negedge clk);
        checks++;
        if (mem_read[d] !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid d%0d busy: got mem_read=%b, want 1", d, mem_read[d]);
        end
        reset = 1;
        @(negedge clk);
        reset = 0;
        f_read[d] = 0;
        checks++;
        if (outs(d) !== '0) begin
            errors++;
            $display("FAIL reset_mid d%0d outputs: got %h, want 0", d, outs(d));
        end
        @(negedge clk);
        checks++;
        if (f_done[d] !== 1'b0 || x_done[d] !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid d%0d no_done: got f=%b x=%b, want 0 0", d, f_done[d], x_done[d]);
        end
        tie_x[0] = 0; tie_x[1] = 0; te[0] = 0; te[1] = 0;
        run("after_reset", d, 1, 0, 0, 64'h3008, 2'd3, '0, '0, '0, 2, 1);
    endtask
    initial begin
        test_reset;
        test_fetch_read;
        test_arbitration;
        test_align;
        test_rw_fault;
        test_timeout;
        test_back_to_back;
        test_random;
        test_reset_mid(0);
        test_reset_mid(1);
        test_reset;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
